// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: default sizes, FSM states and phase names.
package phase_sequencer_pkg;

  localparam int NPHASE_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int P_IF  = 0;
  localparam int P_RD  = 1;
  localparam int P_EX  = 2;
  localparam int P_MEM = 3;
  localparam int P_WB  = 4;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the board/ctl side (master) and the sequencer (slave).
interface phase_sequencer_if
  import phase_sequencer_pkg::*;
#(
  parameter int NPHASE = NPHASE_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              exec;
  logic              step_mode;
  logic              halt;
  logic              stall;
  logic [NPHASE-1:0] skip_mask;
  logic [NPHASE-1:0] p;
  logic              running;
  logic              halted;
  logic              inst_done;
  logic [CNT_W-1:0]  inst_cnt;

  modport master (
    output exec, step_mode, halt, stall, skip_mask,
    input  p, running, halted, inst_done, inst_cnt
  );

  modport slave (
    input  exec, step_mode, halt, stall, skip_mask,
    output p, running, halted, inst_done, inst_cnt
  );

endinterface

// File: rtl/phase_sequencer_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Shift the raw level through two synchroniser stages and keep one stage of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase-enable generator with run/pause, single-step, phase skip,
// stall hold, sticky halt and a retired-instruction counter.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NPHASE = NPHASE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  phase_sequencer_if.slave  bus
);

  localparam logic [NPHASE-1:0] FETCH_ONE_HOT = NPHASE'(1);

  state_e            r_state;
  state_e            w_stateNext;
  logic [NPHASE-1:0] r_p;
  logic [NPHASE-1:0] w_pNext;
  logic [NPHASE-1:0] w_searchP;
  logic              w_found;
  logic              r_stopPend;
  logic              w_stopNext;
  logic              r_instDone;
  logic              w_doneNext;
  logic [CNT_W-1:0]  r_instCnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_execRise;

  sync_edge u_execSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.exec),
    .o_rise  (w_execRise)
  );

  // Find the lowest non-skipped phase above the current one; none found means last phase.
  always_comb begin : nextPhaseSearch
    logic passed;
    passed    = 1'b0;
    w_found   = 1'b0;
    w_searchP = '0;
    for (int j = 0; j < NPHASE; j++) begin
      if (passed && !w_found && !bus.skip_mask[j]) begin
        w_found      = 1'b1;
        w_searchP[j] = 1'b1;
      end
      if (r_p[j]) begin
        passed = 1'b1;
      end
    end
  end

  // Next-state logic: start on exec, advance phases, retire and pick RUN/IDLE/HALT at boundary.
  always_comb begin
    w_stateNext = r_state;
    w_pNext     = r_p;
    w_stopNext  = r_stopPend;
    w_doneNext  = 1'b0;
    w_cntNext   = r_instCnt;
    case (r_state)
      ST_IDLE: begin
        if (w_execRise) begin
          w_stateNext = ST_RUN;
          w_pNext     = FETCH_ONE_HOT;
        end
      end
      ST_RUN: begin
        if (w_execRise) begin
          w_stopNext = 1'b1;
        end
        if (!bus.stall) begin
          if (w_found) begin
            w_pNext = w_searchP;
          end else begin
            w_doneNext = 1'b1;
            w_cntNext  = r_instCnt + CNT_W'(1);
            if (bus.halt) begin
              w_stateNext = ST_HALT;
              w_pNext     = '0;
              w_stopNext  = 1'b0;
            end else if (r_stopPend || bus.step_mode) begin
              w_stateNext = ST_IDLE;
              w_pNext     = '0;
              w_stopNext  = 1'b0;
            end else begin
              w_pNext = FETCH_ONE_HOT;
            end
          end
        end
      end
      ST_HALT: begin
        w_pNext = '0;
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_pNext     = '0;
        w_stopNext  = 1'b0;
      end
    endcase
  end

  // State, phase vector, stop request, retire pulse and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_p        <= '0;
      r_stopPend <= 1'b0;
      r_instDone <= 1'b0;
      r_instCnt  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_p        <= w_pNext;
      r_stopPend <= w_stopNext;
      r_instDone <= w_doneNext;
      r_instCnt  <= w_cntNext;
    end
  end

  assign bus.p         = r_p;
  assign bus.running   = (r_state == ST_RUN);
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.inst_done = r_instDone;
  assign bus.inst_cnt  = r_instCnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: behavioural model compared every cycle plus literal spot checks.
module tb_phase_sequencer;

  localparam int NP = 5;
  localparam int CW = 16;

  logic clk;
  logic rst_n;

  phase_sequencer_if #(.NPHASE(NP), .CNT_W(CW)) bus ();

  phase_sequencer #(.NPHASE(NP), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int nChecks = 0;
  int nFails  = 0;
  bit cmpEn   = 1'b0;

  // Model state, kept as phase index and flags rather than one-hot vectors.
  int              mPhase;
  bit              mRun;
  bit              mHalt;
  bit              mStop;
  bit              mDone;
  logic [CW-1:0]   mCnt;
  bit   [2:0]      mHist;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      if (nFails <= 40)
        $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: exec seen two samples late, lowest non-skipped later phase, retire rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = 0; mRun = 0; mHalt = 0; mStop = 0; mDone = 0; mCnt = '0; mHist = '0;
    end else begin
      bit rise;
      bit oldStop;
      int nxt;
      rise    = mHist[1] & ~mHist[2];
      oldStop = mStop;
      mDone   = 0;
      if (mRun) begin
        if (rise) mStop = 1;
        if (!bus.stall) begin
          nxt = -1;
          for (int j = mPhase + 1; j < NP; j++) begin
            if (nxt < 0 && !bus.skip_mask[j]) nxt = j;
          end
          if (nxt >= 0) begin
            mPhase = nxt;
          end else begin
            mDone = 1;
            mCnt  = mCnt + 1'b1;
            if (bus.halt) begin
              mRun = 0; mHalt = 1; mStop = 0;
            end else if (oldStop || bus.step_mode) begin
              mRun = 0; mStop = 0;
            end else begin
              mPhase = 0;
            end
          end
        end
      end else if (!mHalt && rise) begin
        mRun   = 1;
        mPhase = 0;
      end
      mHist = {mHist[1:0], bus.exec};
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (cmpEn && rst_n) begin
      logic [NP-1:0] expP;
      expP = mRun ? (NP'(1) << mPhase) : '0;
      checkOutput("p", 32'(bus.p), 32'(expP));
      checkOutput("running", 32'(bus.running), 32'(mRun));
      checkOutput("halted", 32'(bus.halted), 32'(mHalt));
      checkOutput("inst_done", 32'(bus.inst_done), 32'(mDone));
      checkOutput("inst_cnt", 32'(bus.inst_cnt), 32'(mCnt));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.exec = 0; bus.step_mode = 0; bus.halt = 0; bus.stall = 0; bus.skip_mask = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic execPulse();
    bus.exec = 1'b1;
    waitCycles(1);
    bus.exec = 1'b0;
  endtask

  // One cycle of randomized inputs; exec is a slowly toggling level.
  task automatic applyStimulus(input int haltOdds);
    @(negedge clk);
    if ($urandom_range(0, 15) == 0) bus.exec = ~bus.exec;
    bus.stall     = ($urandom_range(0, 3) == 0);
    bus.halt      = ($urandom_range(0, haltOdds) == 0);
    bus.skip_mask = NP'($urandom) & NP'($urandom);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    bus.exec = 0; bus.step_mode = 0; bus.halt = 0; bus.stall = 0; bus.skip_mask = '0;
    applyReset();
    cmpEn = 1'b1;
    waitCycles(1);
    checkOutput("rst_p", 32'(bus.p), 32'h0);
    checkOutput("rst_running", 32'(bus.running), 32'h0);
    checkOutput("rst_cnt", 32'(bus.inst_cnt), 32'h0);

    // Free run, no skips: 1,2,4,8,16,1 then stop on an exec press.
    bus.exec = 1'b1;
    waitCycles(3);
    checkOutput("run_first_p", 32'(bus.p), 32'h1);
    bus.exec = 1'b0;
    waitCycles(1); checkOutput("run_p2", 32'(bus.p), 32'h2);
    waitCycles(1); checkOutput("run_p4", 32'(bus.p), 32'h4);
    waitCycles(1); checkOutput("run_p8", 32'(bus.p), 32'h8);
    waitCycles(1); checkOutput("run_p16", 32'(bus.p), 32'h10);
    waitCycles(1); checkOutput("run_wrap_p", 32'(bus.p), 32'h1);
    checkOutput("run_done1", 32'(bus.inst_done), 32'h1);
    checkOutput("run_cnt1", 32'(bus.inst_cnt), 32'h1);
    waitCycles(15);
    checkOutput("run_cnt4", 32'(bus.inst_cnt), 32'h4);
    execPulse();
    waitCycles(9);
    checkOutput("stop_running", 32'(bus.running), 32'h0);
    checkOutput("stop_cnt5", 32'(bus.inst_cnt), 32'h5);

    // Single step with a 3-cycle stall on phase 2.
    bus.step_mode = 1'b1;
    execPulse();
    waitCycles(2);
    checkOutput("step_p1", 32'(bus.p), 32'h1);
    waitCycles(2);
    checkOutput("stall_pre", 32'(bus.p), 32'h4);
    bus.stall = 1'b1;
    waitCycles(3);
    bus.stall = 1'b0;
    checkOutput("stall_hold", 32'(bus.p), 32'h4);
    waitCycles(1); checkOutput("stall_p8", 32'(bus.p), 32'h8);
    waitCycles(1); checkOutput("step_p16", 32'(bus.p), 32'h10);
    waitCycles(1);
    checkOutput("step_end_p", 32'(bus.p), 32'h0);
    checkOutput("step_done", 32'(bus.inst_done), 32'h1);
    checkOutput("step_cnt6", 32'(bus.inst_cnt), 32'h6);
    bus.step_mode = 1'b0;

    // All phases skipped, then halt; halted must ignore exec.
    bus.skip_mask = '1;
    execPulse();
    waitCycles(2);
    checkOutput("skipall_p", 32'(bus.p), 32'h1);
    waitCycles(1);
    checkOutput("skipall_done", 32'(bus.inst_done), 32'h1);
    bus.halt = 1'b1;
    waitCycles(1);
    bus.halt = 1'b0;
    checkOutput("halt_halted", 32'(bus.halted), 32'h1);
    checkOutput("halt_p", 32'(bus.p), 32'h0);
    execPulse();
    waitCycles(6);
    checkOutput("halt_sticky", 32'(bus.halted), 32'h1);

    // Counter wrap: one retire per cycle from zero.
    applyReset();
    bus.skip_mask = '1;
    execPulse();
    waitCycles(2);
    checkOutput("wrap_start_cnt", 32'(bus.inst_cnt), 32'h0);
    waitCycles(65535);
    checkOutput("wrap_ffff", 32'(bus.inst_cnt), 32'hFFFF);
    waitCycles(1);
    checkOutput("wrap_zero", 32'(bus.inst_cnt), 32'h0);

    // Asynchronous reset while phase 3 is active.
    bus.skip_mask = '0;
    guard = 0;
    while (bus.p !== NP'(8) && guard < 20) begin
      waitCycles(1);
      guard++;
    end
    checkOutput("reach_p8", 32'(bus.p), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_p", 32'(bus.p), 32'h0);
    checkOutput("async_running", 32'(bus.running), 32'h0);
    checkOutput("async_done", 32'(bus.inst_done), 32'h0);
    checkOutput("async_cnt", 32'(bus.inst_cnt), 32'h0);
    waitCycles(2);
    #2 rst_n = 1'b1;

    // Randomized segments against the model, reset between to leave HALTED.
    for (int seg = 0; seg < 6; seg++) begin
      applyReset();
      bus.step_mode = seg[0];
      for (int c = 0; c < 1200; c++) applyStimulus(seg < 3 ? 400 : 4000);
    end

    waitCycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
